// File: rtl/fifod2mac.sv
//-----------------------------------------------------------------------------
// fifod2mac
//
// Drains ADC sample bytes from the fifod read port into the MAC UDP transmit
// byte interface, one frame per start request from cs. Every frame begins
// with a 4-byte header (HEAD0, HEAD1, dev_info, frame_cnt) followed by
// len-4 bytes read from fifod. If fifod runs dry, zero bytes are substituted
// and the sticky err flag is raised. Runs entirely in the MAC tx clock domain.
//
// Ports:
//   clk               MAC tx clock
//   rst_n             synchronous active-low reset
//   fs                frame start level from cs (held until fd=1)
//   fd                frame done level to cs (held until fs=0)
//   eth_tx_len        UDP payload length in bytes, header included
//   dev_info          header byte 2
//   flag_udp_tx_prep  mac header phase in progress
//   flag_udp_tx_req   mac requests one payload byte this cycle
//   udp_txen          udp_txd valid (one cycle after the request)
//   udp_txd           payload byte to mac
//   fifod_rxen        fifod read enable
//   fifod_rxd         fifod data, valid one cycle after fifod_rxen
//   fifod_empty       fifod empty flag
//   frame_cnt         completed frame counter, also header byte 3
//   err               sticky error flag (short length or fifod underflow)
//
// Build option:
//   FIFOD2MAC_CHKSUM_EN  when defined, the last payload byte is replaced by
//                        the XOR of all earlier bytes of the frame, and no
//                        fifod read is made for it.
//-----------------------------------------------------------------------------
module fifod2mac #(
  parameter logic [7:0] HEAD0 = 8'h55,
  parameter logic [7:0] HEAD1 = 8'hAA,
  parameter int         LEN_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fs,
  output logic             fd,
  input  logic [LEN_W-1:0] eth_tx_len,
  input  logic [7:0]       dev_info,
  input  logic             flag_udp_tx_prep,
  input  logic             flag_udp_tx_req,
  output logic             udp_txen,
  output logic [7:0]       udp_txd,
  output logic             fifod_rxen,
  input  logic [7:0]       fifod_rxd,
  input  logic             fifod_empty,
  output logic [7:0]       frame_cnt,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SEND,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] idx;
  logic             issue;
  logic             hdr_slot;
  logic             fifo_slot;
  logic [7:0]       hdr_byte;
  logic [7:0]       byte_reg;
  logic             sel_fifo;
  logic             txen_reg;

`ifdef FIFOD2MAC_CHKSUM_EN
  logic             last_slot;
  logic [7:0]       chk;
  logic [7:0]       chk_nx;
`endif

  // A byte is issued whenever mac requests one in SEND and the frame still
  // has bytes left; requests beyond len are silently ignored.
  always_comb begin
    issue    = (state == SEND) && flag_udp_tx_req && (idx < len);
    hdr_slot = (idx < LEN_W'(4));
`ifdef FIFOD2MAC_CHKSUM_EN
    last_slot = (idx == (len - LEN_W'(1)));
    fifo_slot = issue && !hdr_slot && !last_slot;
    chk_nx    = chk ^ (txen_reg ? udp_txd : 8'h00);
`else
    fifo_slot = issue && !hdr_slot;
`endif
    fifod_rxen = rst_n && fifo_slot && !fifod_empty;
  end

  // Header bytes come from a small mux keyed on the low index bits; the
  // selected byte is registered so it lines up with fifod's one-cycle latency.
  always_comb begin
    hdr_byte = HEAD0;
    case (idx[1:0])
      2'd0:    hdr_byte = HEAD0;
      2'd1:    hdr_byte = HEAD1;
      2'd2:    hdr_byte = dev_info;
      default: hdr_byte = frame_cnt;
    endcase
  end

  // Next-state logic. SEND leaves for DONE once every byte has been issued,
  // i.e. on the cycle the final byte is being presented to mac.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (fs) begin
          if (eth_tx_len < LEN_W'(5)) state_nx = DONE;
          else                        state_nx = WAIT;
        end
      end
      WAIT: begin
        if (flag_udp_tx_prep) state_nx = SEND;
      end
      SEND: begin
        if (idx == len) state_nx = DONE;
      end
      DONE: begin
        if (!fs) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register plus all datapath registers. A reset in the middle of a
  // frame simply drops it: fifod_rxen is also gated by rst_n so no read is
  // made on the reset cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      len       <= '0;
      idx       <= '0;
      byte_reg  <= 8'h00;
      sel_fifo  <= 1'b0;
      txen_reg  <= 1'b0;
      frame_cnt <= 8'h00;
      err       <= 1'b0;
`ifdef FIFOD2MAC_CHKSUM_EN
      chk       <= 8'h00;
`endif
    end else begin
      state    <= state_nx;
      txen_reg <= issue;
      sel_fifo <= fifo_slot && !fifod_empty;
      byte_reg <= 8'h00;

      if (state == IDLE && fs) begin
        len <= eth_tx_len;
        idx <= '0;
        if (eth_tx_len < LEN_W'(5)) err <= 1'b1;
      end

      if (issue) begin
        idx <= idx + LEN_W'(1);
        if (hdr_slot) byte_reg <= hdr_byte;
`ifdef FIFOD2MAC_CHKSUM_EN
        else if (last_slot) byte_reg <= chk_nx;
`endif
      end

      if (fifo_slot && fifod_empty) err <= 1'b1;

      if (state == SEND && state_nx == DONE) frame_cnt <= frame_cnt + 8'd1;

`ifdef FIFOD2MAC_CHKSUM_EN
      chk <= (state == IDLE) ? 8'h00 : chk_nx;
`endif
    end
  end

  // Output byte is a combinational mux with a registered select, so fifod
  // data passes straight through in the cycle after the read.
  always_comb begin
    udp_txd  = sel_fifo ? fifod_rxd : byte_reg;
    udp_txen = txen_reg;
    fd       = (state == DONE);
  end

endmodule

// File: tb/tb_fifod2mac.sv
//-----------------------------------------------------------------------------
// tb_fifod2mac
//
// Randomised scoreboard bench for fifod2mac. Each frame's expected byte
// stream is pushed into a queue when the frame is launched; a monitor on the
// falling clock edge pops and compares every byte the DUT presents. A simple
// array-backed fifod model serves read requests with one cycle of latency.
//-----------------------------------------------------------------------------
module tb_fifod2mac;

  localparam int LEN_W = 12;

  logic             clk;
  logic             rst_n;
  logic             fs;
  logic             fd;
  logic [LEN_W-1:0] eth_tx_len;
  logic [7:0]       dev_info;
  logic             flag_udp_tx_prep;
  logic             flag_udp_tx_req;
  logic             udp_txen;
  logic [7:0]       udp_txd;
  logic             fifod_rxen;
  logic [7:0]       fifod_rxd;
  logic             fifod_empty;
  logic [7:0]       frame_cnt;
  logic             err;

  int n_cmp;
  int n_err;

  logic [7:0] mem [0:4095];
  int         wr_ptr;
  int         rd_ptr;
  int         rd_count;

  logic [7:0] exp_q [$];
  logic [7:0] model_cnt;
  logic       model_err;

  fifod2mac #(
    .HEAD0(8'h55),
    .HEAD1(8'hAA),
    .LEN_W(LEN_W)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fs               (fs),
    .fd               (fd),
    .eth_tx_len       (eth_tx_len),
    .dev_info         (dev_info),
    .flag_udp_tx_prep (flag_udp_tx_prep),
    .flag_udp_tx_req  (flag_udp_tx_req),
    .udp_txen         (udp_txen),
    .udp_txd          (udp_txd),
    .fifod_rxen       (fifod_rxen),
    .fifod_rxd        (fifod_rxd),
    .fifod_empty      (fifod_empty),
    .frame_cnt        (frame_cnt),
    .err              (err)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run can never hang.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  assign fifod_empty = (rd_ptr == wr_ptr);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // fifod model: data appears one cycle after the read enable. A read while
  // the model is empty is itself an error.
  always @(posedge clk) begin
    if (fifod_rxen) begin
      if (fifod_empty) begin
        n_cmp++;
        n_err++;
        $display("[TB] FAIL rd_when_empty: got rxen=1 expected rxen=0");
      end else begin
        fifod_rxd <= mem[rd_ptr % 4096];
        rd_ptr    <= rd_ptr + 1;
        rd_count  <= rd_count + 1;
      end
    end
  end

  // Scoreboard monitor: every presented byte must match the head of the
  // expected queue.
  always @(negedge clk) begin
    if (udp_txen) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_byte", {31'd0, udp_txen}, 32'd0);
      end else begin
        checkOutput("udp_txd", {24'd0, udp_txd}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fd;
    int k;
    k = 0;
    while (!fd && k < 60) begin
      tick();
      k++;
    end
    checkOutput("fd_rise", {31'd0, fd}, 32'd1);
  endtask

  // Launch one frame. mode: 0 req held, 1 req toggling, 2 random req.
  // seq loads data bytes 1,2,3,... instead of random values.
  task automatic applyStimulus(input int len, input logic [7:0] info, input int nfifo,
                               input int mode, input int extra, input bit seq);
    logic [7:0] data [$];
    logic [7:0] bytes [$];
    logic [7:0] b;
    logic [7:0] x;
    int need;
    int reqs;
    int rd0;
    int cyc;

`ifdef FIFOD2MAC_CHKSUM_EN
    need = (len >= 5) ? len - 5 : 0;
`else
    need = (len >= 5) ? len - 4 : 0;
`endif
    if (nfifo > need) nfifo = need;

    for (int i = 0; i < nfifo; i++) begin
      b = seq ? 8'(i + 1) : 8'($urandom);
      data.push_back(b);
      mem[wr_ptr % 4096] = b;
      wr_ptr++;
    end

    if (len >= 5) begin
      x = 8'h00;
      for (int i = 0; i < len; i++) begin
        if (i == 0)      b = 8'h55;
        else if (i == 1) b = 8'hAA;
        else if (i == 2) b = info;
        else if (i == 3) b = model_cnt;
`ifdef FIFOD2MAC_CHKSUM_EN
        else if (i == len - 1) b = x;
`endif
        else             b = (i - 4 < nfifo) ? data[i - 4] : 8'h00;
        x = x ^ b;
        bytes.push_back(b);
      end
      foreach (bytes[i]) exp_q.push_back(bytes[i]);
      if (nfifo < need) model_err = 1'b1;
      model_cnt = model_cnt + 8'd1;
    end else begin
      model_err = 1'b1;
    end

    rd0        = rd_count;
    eth_tx_len = LEN_W'(len);
    dev_info   = info;
    fs         = 1'b1;
    tick();

    if (len >= 5) begin
      cyc = $urandom_range(1, 3);
      for (int i = 0; i < cyc; i++) begin
        flag_udp_tx_req = 1'($urandom);
        tick();
      end
      flag_udp_tx_req  = 1'b0;
      flag_udp_tx_prep = 1'b1;
      tick();
      flag_udp_tx_prep = 1'b0;
      reqs = 0;
      cyc  = 0;
      while (reqs < len + extra) begin
        if (mode == 0)      flag_udp_tx_req = 1'b1;
        else if (mode == 1) flag_udp_tx_req = ~cyc[0];
        else                flag_udp_tx_req = 1'($urandom);
        tick();
        if (flag_udp_tx_req) reqs++;
        cyc++;
      end
      flag_udp_tx_req = 1'b0;
    end

    wait_fd();
    checkOutput("frame_cnt", {24'd0, frame_cnt}, {24'd0, model_cnt});
    checkOutput("err", {31'd0, err}, {31'd0, model_err});
    checkOutput("bytes_left", exp_q.size(), 32'd0);
    checkOutput("fifod_reads", rd_count - rd0, nfifo);
    tick();
    tick();
    checkOutput("fd_hold", {31'd0, fd}, 32'd1);
    fs = 1'b0;
    tick();
    checkOutput("fd_drop", {31'd0, fd}, 32'd0);
  endtask

  initial begin
    int len;
    int need;
    int nf;
    int rd0;

    n_cmp            = 0;
    n_err            = 0;
    wr_ptr           = 0;
    rd_ptr           = 0;
    rd_count         = 0;
    fifod_rxd        = 8'h00;
    model_cnt        = 8'h00;
    model_err        = 1'b0;
    rst_n            = 1'b0;
    fs               = 1'b0;
    eth_tx_len       = '0;
    dev_info         = 8'h00;
    flag_udp_tx_prep = 1'b0;
    flag_udp_tx_req  = 1'b0;

    repeat (3) tick();
    checkOutput("rst_fd", {31'd0, fd}, 32'd0);
    checkOutput("rst_txen", {31'd0, udp_txen}, 32'd0);
    checkOutput("rst_txd", {24'd0, udp_txd}, 32'd0);
    checkOutput("rst_rxen", {31'd0, fifod_rxen}, 32'd0);
    checkOutput("rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] basic frame, req held");
    applyStimulus(8, 8'h21, 8, 0, 0, 1'b1);

    $display("[TB] toggling req, requests past len");
    applyStimulus(8, 8'h21, 8, 1, 3, 1'b1);

    $display("[TB] fifod underflow");
    applyStimulus(8, 8'h21, 2, 0, 0, 1'b1);

    $display("[TB] short length");
    applyStimulus(3, 8'h21, 0, 0, 0, 1'b1);

    $display("[TB] reset in the middle of SEND");
    mem[wr_ptr % 4096] = 8'h9C;
    wr_ptr++;
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h3E);
    exp_q.push_back(model_cnt);
    exp_q.push_back(8'h9C);
    rd0        = rd_count;
    eth_tx_len = LEN_W'(8);
    dev_info   = 8'h3E;
    fs         = 1'b1;
    tick();
    flag_udp_tx_prep = 1'b1;
    tick();
    flag_udp_tx_prep = 1'b0;
    flag_udp_tx_req  = 1'b1;
    repeat (5) tick();
    flag_udp_tx_req = 1'b0;
    rst_n           = 1'b0;
    tick();
    checkOutput("mid_rst_fd", {31'd0, fd}, 32'd0);
    checkOutput("mid_rst_txen", {31'd0, udp_txen}, 32'd0);
    checkOutput("mid_rst_txd", {24'd0, udp_txd}, 32'd0);
    checkOutput("mid_rst_rxen", {31'd0, fifod_rxen}, 32'd0);
    checkOutput("mid_rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
    checkOutput("mid_rst_err", {31'd0, err}, 32'd0);
    checkOutput("mid_rst_bytes_left", exp_q.size(), 32'd0);
    checkOutput("mid_rst_reads", rd_count - rd0, 32'd1);
    rst_n     = 1'b1;
    fs        = 1'b0;
    model_cnt = 8'h00;
    model_err = 1'b0;
    tick();
    tick();
    checkOutput("post_rst_fd", {31'd0, fd}, 32'd0);

    $display("[TB] random back-to-back frames");
    for (int f = 0; f < 300; f++) begin
      if ($urandom_range(0, 15) == 0) len = $urandom_range(0, 4);
      else                            len = $urandom_range(5, 16);
`ifdef FIFOD2MAC_CHKSUM_EN
      need = (len >= 5) ? len - 5 : 0;
`else
      need = (len >= 5) ? len - 4 : 0;
`endif
      nf = need;
      if (need > 0 && $urandom_range(0, 9) == 0) nf = $urandom_range(0, need - 1);
      applyStimulus(len, 8'($urandom), nf, 2, $urandom_range(0, 3), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
